// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: fetch state encoding,
// the NOP word and a PC legality helper.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // A fetch address is usable only if word-aligned and inside instruction memory.
  function automatic logic pc_legal(input logic [31:0] addr, input logic [31:0] last_pc);
    return (addr[1:0] == 2'b00) && (addr <= last_pc);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage, instruction memory, hazard/branch logic and decode.
interface instruction_fetch_if;
  import mips_pkg::*;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_address;
  logic [31:0] ir;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_err;

  modport master (
    input  stall, redirect, redirect_pc, ir,
    output pc_address, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_err
  );

  modport slave (
    output stall, redirect, redirect_pc, ir,
    input  pc_address, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_err
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with bubble (flush), hold (stall) and load controls.
// Bubble wins over hold, hold wins over load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold && load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, presents it to instruction memory and feeds IF/ID.
// Handles redirect, stall, halt word and running off the end of memory.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 8192,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_WORDS) * WORD_BYTES - WORD_BYTES;

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic         fetch_err, err_next;
  logic         end_pending, end_next;
  logic         ifid_load, ifid_bubble;

  assign pc_plus4 = pc + WORD_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_err   <= 1'b0;
      end_pending <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_err   <= err_next;
      end_pending <= end_next;
    end
  end

  // end_pending marks that the last word of memory was just delivered,
  // so the following non-stalled edge halts with an error instead of wrapping.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    err_next    = fetch_err;
    end_next    = end_pending;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (bus.redirect) begin
          ifid_bubble = 1'b1;
          end_next    = 1'b0;
          if (pc_legal(bus.redirect_pc, LAST_PC)) begin
            pc_next = bus.redirect_pc;
          end else begin
            state_next = HALT;
            err_next   = 1'b1;
          end
        end else if (bus.stall) begin
          ifid_load = 1'b0;
        end else if (end_pending) begin
          state_next  = HALT;
          err_next    = 1'b1;
          ifid_bubble = 1'b1;
        end else if (bus.ir == HALT_WORD) begin
          state_next  = HALT;
          ifid_bubble = 1'b1;
        end else begin
          ifid_load = 1'b1;
          if (pc_plus4 > LAST_PC || pc_plus4 < pc) begin
            end_next = 1'b1;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      default: state_next = HALT;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (bus.stall),
    .bubble     (ifid_bubble),
    .load       (ifid_load),
    .next_instr (bus.ir),
    .next_pc4   (pc_plus4),
    .instr      (bus.if_id_instr),
    .pc4        (bus.if_id_pc4),
    .valid      (bus.if_id_valid)
  );

  assign bus.pc_address = pc;
  assign bus.halted     = (state == HALT);
  assign bus.fetch_err  = fetch_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: spec-level model compared every cycle
// plus directed vectors with hand-computed expectations.
module tb_instruction_fetch;
  import mips_pkg::*;

  localparam int          WORDS    = 8192;
  localparam longint      LAST     = 64'(WORDS) * 4 - 4;
  localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic check_en;
  int   assertions = 0;
  int   failures   = 0;

  logic [31:0] mem [WORDS];

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (WORDS),
    .HALT_WORD  (HALT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ir = mem[bus.pc_address[14:2]];

  // Reference model of the fetch rules, kept in terms of addresses and flags.
  logic        m_boot, m_halted, m_err, m_end, m_valid;
  logic [31:0] m_pc, m_instr, m_pc4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_halted <= 1'b0; m_err <= 1'b0; m_end <= 1'b0;
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_halted) begin
      if (bus.redirect) begin
        m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_end <= 1'b0;
        if ((bus.redirect_pc % 4) != 0 || longint'(bus.redirect_pc) > LAST) begin
          m_halted <= 1'b1; m_err <= 1'b1;
        end else begin
          m_pc <= bus.redirect_pc;
        end
      end else if (!bus.stall) begin
        if (m_end) begin
          m_halted <= 1'b1; m_err <= 1'b1;
          m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else if (mem[m_pc / 4] == HALT_W) begin
          m_halted <= 1'b1;
          m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else begin
          m_instr <= mem[m_pc / 4];
          m_pc4   <= m_pc + 32'd4;
          m_valid <= 1'b1;
          if (longint'(m_pc) + 4 > LAST) m_end <= 1'b1;
          else m_pc <= m_pc + 32'd4;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Model comparison on every falling edge once the bench is running.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_pc",     bus.pc_address,  m_pc);
      checkOutput("model_instr",  bus.if_id_instr, m_instr);
      checkOutput("model_pc4",    bus.if_id_pc4,   m_pc4);
      checkOutput("model_valid",  32'(bus.if_id_valid), 32'(m_valid));
      checkOutput("model_halted", 32'(bus.halted),      32'(m_halted));
      checkOutput("model_err",    32'(bus.fetch_err),   32'(m_err));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = 32'h0;
    mem[4] = HALT_W;
    mem[16] = 32'h2010_0040; mem[17] = 32'h2011_0044;
    mem[8188] = 32'h2000_7FF0; mem[8189] = 32'h2000_7FF4;
    mem[8190] = 32'h2000_7FF8; mem[8191] = 32'h2000_7FFC;

    check_en = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #12;
    checkOutput("rst_pc",     bus.pc_address, 32'h0);
    checkOutput("rst_valid",  32'(bus.if_id_valid), 32'h0);
    checkOutput("rst_halted", 32'(bus.halted), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    tick(1);
    checkOutput("boot_pc",    bus.pc_address, 32'h0);
    checkOutput("boot_valid", 32'(bus.if_id_valid), 32'h0);
    tick(1);
    checkOutput("seq0_instr", bus.if_id_instr, 32'h2008_0001);
    checkOutput("seq0_pc4",   bus.if_id_pc4, 32'h4);
    checkOutput("seq0_valid", 32'(bus.if_id_valid), 32'h1);
    tick(1);
    checkOutput("seq1_instr", bus.if_id_instr, 32'h2009_0002);
    checkOutput("seq1_pc",    bus.pc_address, 32'h8);

    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(3);
    checkOutput("stall_pc",    bus.pc_address, 32'h8);
    checkOutput("stall_instr", bus.if_id_instr, 32'h2009_0002);
    checkOutput("stall_pc4",   bus.if_id_pc4, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick(1);
    checkOutput("resume_instr", bus.if_id_instr, 32'h0109_5020);
    checkOutput("resume_pc4",   bus.if_id_pc4, 32'hC);

    applyStimulus(1'b1, 1'b1, 32'h40);
    tick(1);
    checkOutput("redir_pc",    bus.pc_address, 32'h40);
    checkOutput("redir_valid", 32'(bus.if_id_valid), 32'h0);
    checkOutput("redir_instr", bus.if_id_instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick(1);
    checkOutput("redir_tgt_instr", bus.if_id_instr, 32'h2010_0040);
    checkOutput("redir_tgt_pc4",   bus.if_id_pc4, 32'h44);

    // Redirect arriving while the halt word is presented cancels the halt.
    applyStimulus(1'b0, 1'b1, 32'h8); tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0); tick(2);
    checkOutput("haltw_pc", bus.pc_address, 32'h10);
    applyStimulus(1'b0, 1'b1, 32'h40); tick(1);
    checkOutput("override_pc",     bus.pc_address, 32'h40);
    checkOutput("override_halted", 32'(bus.halted), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0); tick(1);
    checkOutput("override_instr",  bus.if_id_instr, 32'h2010_0040);

    applyStimulus(1'b0, 1'b1, 32'h8); tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0); tick(3);
    checkOutput("halt_halted", 32'(bus.halted), 32'h1);
    checkOutput("halt_err",    32'(bus.fetch_err), 32'h0);
    checkOutput("halt_pc",     bus.pc_address, 32'h10);
    checkOutput("halt_valid",  32'(bus.if_id_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40); tick(2);
    checkOutput("halt_ignore_pc", bus.pc_address, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0);

    doReset();
    applyStimulus(1'b0, 1'b1, 32'h42); tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("misalign_halted", 32'(bus.halted), 32'h1);
    checkOutput("misalign_err",    32'(bus.fetch_err), 32'h1);

    doReset();
    applyStimulus(1'b0, 1'b1, 32'h8000); tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("range_halted", 32'(bus.halted), 32'h1);
    checkOutput("range_err",    32'(bus.fetch_err), 32'h1);

    doReset();
    applyStimulus(1'b0, 1'b1, 32'h7FF0); tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0); tick(4);
    checkOutput("last_instr",  bus.if_id_instr, 32'h2000_7FFC);
    checkOutput("last_pc4",    bus.if_id_pc4, 32'h8000);
    checkOutput("last_valid",  32'(bus.if_id_valid), 32'h1);
    checkOutput("last_halted", 32'(bus.halted), 32'h0);
    tick(1);
    checkOutput("end_halted", 32'(bus.halted), 32'h1);
    checkOutput("end_err",    32'(bus.fetch_err), 32'h1);
    checkOutput("end_pc",     bus.pc_address, 32'h7FFC);
    checkOutput("end_valid",  32'(bus.if_id_valid), 32'h0);

    // Asynchronous reset in the middle of a cycle.
    doReset();
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pc",    bus.pc_address, 32'h0);
    checkOutput("async_instr", bus.if_id_instr, 32'h0);
    checkOutput("async_pc4",   bus.if_id_pc4, 32'h0);
    checkOutput("async_valid", 32'(bus.if_id_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    checkOutput("reboot_pc",    bus.pc_address, 32'h0);
    checkOutput("reboot_valid", 32'(bus.if_id_valid), 32'h0);
    tick(1);
    checkOutput("reboot_instr", bus.if_id_instr, 32'h2008_0001);
    checkOutput("reboot_pc4",   bus.if_id_pc4, 32'h4);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
